prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time loader upstream of the instruction and data bram32 instances and the pc stall input.
- Consumes a byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them into the instruction or data BRAM write ports.
- Holds the core stalled until a GO command, replacing the bench-driven load loops.

Parameters:
- DATA_WIDTH, 32, word width written to BRAMs.
- ADDR_WIDTH, 10, BRAM byte-address width (w_addr).
- MAX_WORDS, 256, maximum words per section.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_dat  input  8  stream byte.
- in_valid  input  1  in_dat valid.
- in_ready  output  1  loader accepts a byte this cycle.
- i_w_addr  output  ADDR_WIDTH  instruction BRAM write address.
- i_w_dat  output  DATA_WIDTH  instruction BRAM write data.
- i_w_enb  output  1  instruction BRAM write enable.
- d_w_addr  output  ADDR_WIDTH  data BRAM write address.
- d_w_dat  output  DATA_WIDTH  data BRAM write data.
- d_w_enb  output  1  data BRAM write enable.
- cpu_stall  output  1  drives pc stall; 1 while loading.
- load_done  output  1  GO received; core running.
- load_err  output  1  protocol error, sticky.
- words_loaded  output  9  words written in current/last section.

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset values:
  - in_ready=1, cpu_stall=1.
  - All w_enb=0, all w_addr/w_dat=0.
  - load_done=0, load_err=0, words_loaded=0.
  - State=IDLE.
- Byte transfer occurs on a rising edge with in_valid&&in_ready. in_dat is ignored otherwise.
- Protocol: command byte, then (for 'I'/'D') count low byte, count high byte, then count×4 payload bytes, LSB first.
- Commands:
  - 0x49 'I' selects instruction BRAM.
  - 0x44 'D' selects data BRAM.
  - 0x47 'G' selects go.
- States: IDLE, CNT_LO, CNT_HI, PAYLOAD, WRITE, RUN, ERR.
- IDLE:
  - 'I'/'D' -> latch target, clear words_loaded and word index, go to CNT_LO.
  - 'G' -> RUN.
  - Any other byte -> ERR.
- CNT_LO: latch low byte -> CNT_HI.
- CNT_HI: latch high byte; 16-bit count.
  - count==0 -> IDLE, no writes.
  - count>MAX_WORDS -> ERR.
  - Else -> PAYLOAD, byte counter=0.
- PAYLOAD:
  - Byte k (0..3) goes into bits [8k+7:8k] of the assembly register.
  - After byte 3 is accepted -> WRITE.
- WRITE (exactly one cycle):
  - Selected w_enb=1, w_addr=index*4, w_dat=assembled word; in_ready=0.
  - Next cycle w_enb=0; index and words_loaded increment.
  - If index+1==count -> IDLE, else -> PAYLOAD.
- Unselected BRAM enables stay 0 throughout.
- w_addr/w_dat are registered and hold their last value when enables are 0.
- Throughput: one word per 5 cycles minimum. Any in_valid gaps stall assembly with no data loss.
- Sections may repeat in any order. A repeated 'I'/'D' restarts at address 0 and overwrites.
- RUN: cpu_stall=0, load_done=1, in_ready=0, all enables 0. Terminal until reset.
- ERR: load_err=1, cpu_stall=1, in_ready=1, bytes discarded, no writes. Terminal until reset.
- Reset mid-operation:
  - Outputs immediately take reset values; a pending write enable is dropped the same instant.
  - The partial word is discarded. The next load restarts cleanly.
- Address width rule: index*4 truncated to ADDR_WIDTH. With the defaults this never wraps (max 0x3FC).

Test Plan:
1. Reset -> in_ready=1, cpu_stall=1, all enables 0, load_done=0, load_err=0, words_loaded=0.
2. Data section:
   - Stimulus: bytes 44 02 00 05 00 00 00 04 00 00 00, continuous valid.
   - Required: two single-cycle d_w_enb pulses, (addr 0x000, dat 00000005) then (addr 0x004, dat 00000004).
   - Required: in_ready=0 on each pulse cycle, i_w_enb never asserted, words_loaded=2.
3. Instruction section plus GO:
   - Stimulus: 49 05 00, then 5 words (e.g. 0x40628333, 0x00000013 ×4), then 47.
   - Required: i_w_enb pulses at 0x000,0x004,0x008,0x00C,0x010 with matching data.
   - Required: after 47, cpu_stall=0, load_done=1, in_ready=0; further bytes cause no writes.
4. Backpressure/gaps:
   - Stimulus: same as scenario 2 with in_valid toggled every other cycle, and a byte held across a WRITE cycle.
   - Required: identical writes, no byte lost or duplicated.
5. Count edge cases:
   - 44 00 00 -> no write, back to IDLE; a following 47 reaches RUN.
   - 49 01 01 (count 257) -> load_err=1, cpu_stall=1, no writes, 47 ignored.
6. Error and reset:
   - Unknown command 0x58 -> load_err=1.
   - rst pulsed mid-word (after 49 01 00 AA BB) -> immediate reset values.
   - Then 49 01 00 78 56 34 12 -> i_w_enb at addr 0x000 with dat 12345678.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words for the
// instruction/data BRAM write ports and keeps the core stalled until a GO command.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_dat,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_err,
  output logic [8:0]            words_loaded
);

  localparam logic [7:0] CMD_INSTR = 8'h49;
  localparam logic [7:0] CMD_DATA  = 8'h44;
  localparam logic [7:0] CMD_GO    = 8'h47;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    PAYLOAD,
    WRITE,
    RUN,
    ERR
  } state_t;

  state_t      state, next_state;
  logic        accept;
  logic        target_data;
  logic [7:0]  count_lo;
  logic [15:0] count;
  logic [15:0] count_full;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic [31:0] full_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign accept     = in_valid && in_ready;
  assign count_full = {in_dat, count_lo};
  assign full_word  = {in_dat, asm_word};
  assign word_addr  = ADDR_WIDTH'({index, 2'b00});

  assign cpu_stall = (state != RUN);
  assign load_done = (state == RUN);
  assign load_err  = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_dat)
            CMD_INSTR, CMD_DATA: next_state = CNT_LO;
            CMD_GO:              next_state = RUN;
            default:             next_state = ERR;
          endcase
        end
      end
      CNT_LO: begin
        if (accept) next_state = CNT_HI;
      end
      CNT_HI: begin
        if (accept) begin
          if (count_full == 16'd0) begin
            next_state = IDLE;
          end else if (count_full > 16'(MAX_WORDS)) begin
            next_state = ERR;
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept && byte_cnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        in_ready = 1'b0;
        if (index + 16'd1 == count) begin
          next_state = IDLE;
        end else begin
          next_state = PAYLOAD;
        end
      end
      RUN: begin
        in_ready = 1'b0;
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = ERR;
      end
    endcase
  end

  // Write port registers load on the last payload byte so the enable pulse
  // coincides with the single WRITE cycle; addr/dat hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_data  <= 1'b0;
      count_lo     <= '0;
      count        <= '0;
      index        <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      i_w_addr     <= '0;
      i_w_dat      <= '0;
      i_w_enb      <= 1'b0;
      d_w_addr     <= '0;
      d_w_dat      <= '0;
      d_w_enb      <= 1'b0;
    end else begin
      i_w_enb <= 1'b0;
      d_w_enb <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (in_dat == CMD_INSTR || in_dat == CMD_DATA)) begin
            target_data  <= (in_dat == CMD_DATA);
            words_loaded <= '0;
            index        <= '0;
          end
        end
        CNT_LO: begin
          if (accept) count_lo <= in_dat;
        end
        CNT_HI: begin
          if (accept) begin
            count    <= count_full;
            byte_cnt <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (target_data) begin
                d_w_enb  <= 1'b1;
                d_w_addr <= word_addr;
                d_w_dat  <= DATA_WIDTH'(full_word);
              end else begin
                i_w_enb  <= 1'b1;
                i_w_addr <= word_addr;
                i_w_dat  <= DATA_WIDTH'(full_word);
              end
            end else begin
              asm_word[{byte_cnt, 3'b000} +: 8] <= in_dat;
            end
          end
        end
        WRITE: begin
          index        <= index + 16'd1;
          words_loaded <= words_loaded + 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: sections, GO, gaps, count limits,
// protocol errors and asynchronous reset behaviour.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_dat;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  int checks = 0;
  int fails  = 0;

  logic [41:0] i_log[$];
  logic [41:0] d_log[$];
  logic [41:0] exp_log[$];
  logic [7:0]  stim[$];

  prog_loader dut (
    .clk(clk), .rst(rst),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every write pulse is logged; the loader must never accept a byte on a pulse cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (i_w_enb) begin
        i_log.push_back({i_w_addr, i_w_dat});
        checkOutput("i_pulse_in_ready", 64'(in_ready), 64'd0);
      end
      if (d_w_enb) begin
        d_log.push_back({d_w_addr, d_w_dat});
        checkOutput("d_pulse_in_ready", 64'(in_ready), 64'd0);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    bit taken;
    int waited;
    taken  = 1'b0;
    waited = 0;
    in_dat   = b;
    in_valid = 1'b1;
    do begin
      taken = in_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!taken && waited < 50);
    if (!taken) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit gaps);
    foreach (stim[k]) begin
      sendByte(stim[k]);
      if (gaps) idleCycles(1);
    end
    in_valid = 1'b0;
    stim.delete();
    idleCycles(2);
  endtask

  task automatic checkLog(input string tag, input bit is_data);
    logic [41:0] got[$];
    got = is_data ? d_log : i_log;
    checkOutput({tag, "_count"}, 64'(got.size()), 64'(exp_log.size()));
    foreach (exp_log[k]) begin
      if (k < got.size()) checkOutput({tag, "_entry"}, 64'(got[k]), 64'(exp_log[k]));
    end
    exp_log.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_log.delete();
    d_log.delete();
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_cpu_stall"}, 64'(cpu_stall), 64'd1);
    checkOutput({tag, "_enables"}, 64'({i_w_enb, d_w_enb}), 64'd0);
    checkOutput({tag, "_addrs"}, 64'({i_w_addr, d_w_addr}), 64'd0);
    checkOutput({tag, "_dats"}, {i_w_dat, d_w_dat}, 64'd0);
    checkOutput({tag, "_flags"}, 64'({load_done, load_err}), 64'd0);
    checkOutput({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_dat   = 8'h00;
    in_valid = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Data section, continuous valid.
    stim = '{8'h44, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    exp_log = '{{10'h000, 32'h00000005}, {10'h004, 32'h00000004}};
    checkLog("data_sec", 1'b1);
    checkLog("data_sec_no_i", 1'b0);
    checkOutput("data_sec_words", 64'(words_loaded), 64'd2);
    checkOutput("data_sec_stall", 64'(cpu_stall), 64'd1);

    // Instruction section then GO.
    stim = '{8'h49, 8'h05, 8'h00,
             8'h33, 8'h83, 8'h62, 8'h40,
             8'h13, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    exp_log = '{{10'h000, 32'h40628333}, {10'h004, 32'h00000013}, {10'h008, 32'h00000013},
                {10'h00C, 32'h00000013}, {10'h010, 32'h00000013}};
    checkLog("instr_sec", 1'b0);
    checkOutput("instr_sec_words", 64'(words_loaded), 64'd5);
    checkOutput("instr_sec_d_untouched", 64'(d_log.size()), 64'd2);
    stim = '{8'h47};
    applyStimulus(1'b0);
    checkOutput("go_stall", 64'(cpu_stall), 64'd0);
    checkOutput("go_done", 64'(load_done), 64'd1);
    checkOutput("go_ready", 64'(in_ready), 64'd0);
    in_dat   = 8'h44;
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("run_no_writes", 64'(i_log.size() + d_log.size()), 64'd7);
    checkOutput("run_sticky", 64'(load_done), 64'd1);

    // Same data section with a gap after every byte.
    doReset();
    stim = '{8'h44, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b1);
    exp_log = '{{10'h000, 32'h00000005}, {10'h004, 32'h00000004}};
    checkLog("gaps", 1'b1);
    checkOutput("gaps_words", 64'(words_loaded), 64'd2);

    // Repeated section restarts at address 0.
    stim = '{8'h44, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(1'b0);
    exp_log = '{{10'h000, 32'h00000005}, {10'h004, 32'h00000004}, {10'h000, 32'hDEADBEEF}};
    checkLog("rewrite", 1'b1);
    checkOutput("rewrite_words", 64'(words_loaded), 64'd1);

    // Zero count returns to IDLE; GO still works.
    doReset();
    stim = '{8'h44, 8'h00, 8'h00};
    applyStimulus(1'b0);
    checkOutput("zero_cnt_writes", 64'(i_log.size() + d_log.size()), 64'd0);
    checkOutput("zero_cnt_flags", 64'({load_done, load_err, in_ready}), 64'b001);
    stim = '{8'h47};
    applyStimulus(1'b0);
    checkOutput("zero_cnt_go", 64'(load_done), 64'd1);

    // Count 257 exceeds the limit.
    doReset();
    stim = '{8'h49, 8'h01, 8'h01, 8'h47};
    applyStimulus(1'b0);
    checkOutput("big_cnt_err", 64'(load_err), 64'd1);
    checkOutput("big_cnt_stall", 64'(cpu_stall), 64'd1);
    checkOutput("big_cnt_ready", 64'(in_ready), 64'd1);
    checkOutput("big_cnt_go_ignored", 64'(load_done), 64'd0);
    checkOutput("big_cnt_writes", 64'(i_log.size() + d_log.size()), 64'd0);

    // Unknown command.
    doReset();
    stim = '{8'h58, 8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b0);
    checkOutput("bad_cmd_err", 64'(load_err), 64'd1);
    checkOutput("bad_cmd_writes", 64'(i_log.size() + d_log.size()), 64'd0);

    // Reset mid-word, then a clean load.
    doReset();
    stim = '{8'h49, 8'h01, 8'h00, 8'hAA, 8'hBB};
    applyStimulus(1'b0);
    #2 rst = 1'b1;
    #1 checkResetOutputs("mid_word_reset");
    @(negedge clk);
    rst = 1'b0;
    i_log.delete();
    @(negedge clk);
    stim = '{8'h49, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    applyStimulus(1'b0);
    exp_log = '{{10'h000, 32'h12345678}};
    checkLog("after_reset", 1'b0);
    checkOutput("after_reset_words", 64'(words_loaded), 64'd1);

    // Reset during the WRITE cycle drops the enable at once.
    stim = '{8'h49, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    foreach (stim[k]) sendByte(stim[k]);
    in_valid = 1'b0;
    stim.delete();
    checkOutput("pulse_before_reset", 64'(i_w_enb), 64'd1);
    #2 rst = 1'b1;
    #1 checkOutput("pulse_dropped", 64'(i_w_enb), 64'd0);
    checkOutput("pulse_dropped_addr_dat", {22'd0, i_w_addr, i_w_dat}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
